// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic initiator that lives beside the user-project slave
// register block. It runs single read/write commands handed to it on a
// local valid/ready command port. It can also read one register (POLL_ADDR)
// on its own at a fixed period and report the value it got back.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   cmd_valid / cmd_ready   command handshake (ready only while idle)
//   cmd_we/adr/dat/sel      command fields, captured on acceptance
//   rsp_valid/dat/err       one-cycle completion pulse, read data, timeout
//   poll_en                 enable the periodic poller
//   poll_val                last successfully polled value
//   poll_upd/chg/err        one-cycle pulses: updated / changed / timed out
//   wbm_*_o, wbm_*_i        Wishbone classic master interface
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_cmd_master #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter logic [31:0] POLL_ADDR      = BASE_ADDRESS + 32'h0000_0014,
  parameter int unsigned POLL_PERIOD    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,

  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,

  input  logic        poll_en,
  output logic [31:0] poll_val,
  output logic        poll_upd,
  output logic        poll_chg,
  output logic        poll_err,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PER_W = $clog2(POLL_PERIOD);

  // The timeout counter holds the number of BUS cycles already spent
  // without an ack, so reaching LAST at an edge means the strobe has been
  // up for TIMEOUT_CYCLES cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(POLL_PERIOD - 1);

  // FSM and bus-side registers
  logic [1:0]       state_q,   state_d;
  logic             cyc_q,     cyc_d;
  logic             we_q,      we_d;
  logic [3:0]       sel_q,     sel_d;
  logic [31:0]      adr_q,     adr_d;
  logic [31:0]      wdat_q,    wdat_d;
  logic             is_poll_q, is_poll_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Poller state
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             pending_q, pending_d;
  logic [31:0]      poll_val_q, poll_val_d;

  // Response / status pulses
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dat_q,   rsp_dat_d;
  logic             rsp_err_q,   rsp_err_d;
  logic             poll_upd_q,  poll_upd_d;
  logic             poll_chg_q,  poll_chg_d;
  logic             poll_err_q,  poll_err_d;

  logic             launch_poll;
  logic             per_wrap;

  // Transfer sequencing. A command beats a pending poll when both are
  // available in IDLE; the poll simply stays pending for the next IDLE.
  // DONE always drops cyc/stb for one cycle so the slave can re-arm its ack.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    is_poll_d   = is_poll_q;
    tmo_cnt_d   = tmo_cnt_q;
    poll_val_d  = poll_val_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = 1'b0;
    poll_upd_d  = 1'b0;
    poll_chg_d  = 1'b0;
    poll_err_d  = 1'b0;
    launch_poll = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_BUS;
          cyc_d     = 1'b1;
          we_d      = cmd_we;
          sel_d     = cmd_sel;
          adr_d     = cmd_adr;
          wdat_d    = cmd_dat;
          is_poll_d = 1'b0;
          tmo_cnt_d = '0;
        end else if (pending_q) begin
          state_d     = ST_BUS;
          cyc_d       = 1'b1;
          we_d        = 1'b0;
          sel_d       = 4'hF;
          adr_d       = POLL_ADDR;
          wdat_d      = 32'h0;
          is_poll_d   = 1'b1;
          tmo_cnt_d   = '0;
          launch_poll = 1'b1;
        end
      end

      ST_BUS: begin
        // An ack arriving on the same edge as the timeout still counts.
        if (wbm_ack_i) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          if (is_poll_q) begin
            poll_val_d = wbm_dat_i;
            poll_upd_d = 1'b1;
            poll_chg_d = (wbm_dat_i != poll_val_q);
          end else begin
            rsp_valid_d = 1'b1;
            rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          if (is_poll_q) begin
            poll_err_d = 1'b1;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = 32'h0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // Poll period timer. A wrap while a poll is still pending is dropped.
  // If a wrap coincides with a pending poll being launched, the wrap wins
  // so that period is not lost.
  always_comb begin
    per_cnt_d = per_cnt_q;
    pending_d = pending_q;
    per_wrap  = 1'b0;
    if (!poll_en) begin
      per_cnt_d = '0;
      pending_d = 1'b0;
    end else begin
      if (per_cnt_q == PER_LAST) begin
        per_cnt_d = '0;
        per_wrap  = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + 1'b1;
      end
      if (per_wrap) begin
        pending_d = 1'b1;
      end else if (launch_poll) begin
        pending_d = 1'b0;
      end
    end
  end

  // State registers. Reset drops cyc/stb immediately and suppresses any
  // response for the transfer that was cut off.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      wdat_q      <= 32'h0;
      is_poll_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      per_cnt_q   <= '0;
      pending_q   <= 1'b0;
      poll_val_q  <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
      poll_upd_q  <= 1'b0;
      poll_chg_q  <= 1'b0;
      poll_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      is_poll_q   <= is_poll_d;
      tmo_cnt_q   <= tmo_cnt_d;
      per_cnt_q   <= per_cnt_d;
      pending_q   <= pending_d;
      poll_val_q  <= poll_val_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      poll_upd_q  <= poll_upd_d;
      poll_chg_q  <= poll_chg_d;
      poll_err_q  <= poll_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);

  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

  assign poll_val  = poll_val_q;
  assign poll_upd  = poll_upd_q;
  assign poll_chg  = poll_chg_q;
  assign poll_err  = poll_err_q;

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
//
// Directed bench for wb_cmd_master. A small Wishbone slave model acks one
// cycle after it sees the strobe, but only for addresses 0x300000xx.
//   +0x04 reads 0x4669626F after reset
//   +0x14 returns pollData, which the bench controls
//   +0x18 is a writable register that reads back through +0x1C
// POLL_PERIOD is 8 so the poller scenarios stay short.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wb_cmd_master;

  localparam logic [31:0] POLL_ADDR = 32'h3000_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0;
  logic [31:0] cmd_dat = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        poll_en = 1'b0;
  logic [31:0] poll_val;
  logic        poll_upd, poll_chg, poll_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, datO;
  logic        ack;
  logic [31:0] datI;

  logic [31:0] mem [0:7];
  logic [31:0] pollData = 32'd5;

  int checks = 0;
  int errors = 0;
  int gapCnt = 0;
  int lastGap = 0;

  wb_cmd_master #(
    .POLL_PERIOD   (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .poll_en  (poll_en),
    .poll_val (poll_val),
    .poll_upd (poll_upd),
    .poll_chg (poll_chg),
    .poll_err (poll_err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(datO),
    .wbm_ack_i(ack),
    .wbm_dat_i(datI)
  );

  always #5 clk = ~clk;

  // Slave model: registered ack one cycle after the strobe is seen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack  <= 1'b0;
      datI <= 32'h0;
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h4669626F;
    end else begin
      ack <= 1'b0;
      if (cyc && stb && !ack && adr[31:8] == 24'h300000) begin
        ack <= 1'b1;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (sel[b]) mem[adr[4:2]][8*b +: 8] <= datO[8*b +: 8];
          datI <= 32'h0;
        end else if (adr == POLL_ADDR) begin
          datI <= pollData;
        end else if (adr[4:2] == 3'd7) begin
          datI <= mem[6];
        end else begin
          datI <= mem[adr[4:2]];
        end
      end
    end
  end

  // Length of the most recent idle stretch on the bus before cyc rose.
  always @(posedge clk) begin
    if (!cyc) begin
      gapCnt = gapCnt + 1;
    end else if (gapCnt != 0) begin
      lastGap = gapCnt;
      gapCnt  = 0;
    end
  end

  // Present a command and hold it until the edge that accepts it.
  // Returns #1 after that edge with cmd_valid already released.
  task automatic driveCmd(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid, counting edges since the caller's reference edge.
  task automatic waitRsp(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if ({cyc, stb} !== 2'b00) begin errors++; $display("[TB] FAIL reset_cyc got %b want 00", {cyc, stb}); end
    checks++; if ({rsp_valid, rsp_err, poll_upd, poll_chg, poll_err} !== 5'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b want 00000", {rsp_valid, rsp_err, poll_upd, poll_chg, poll_err}); end
    checks++; if (poll_val !== 32'h0) begin errors++; $display("[TB] FAIL reset_poll_val got %h want 0", poll_val); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read;
    bit ok, seen;
    int lat;
    driveCmd(1'b0, 32'h3000_0004, 32'h0, 4'hF, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL read_accept got not-ready want ready"); end
    checks++; if ({cyc, stb, we} !== 3'b110 || adr !== 32'h3000_0004 || sel !== 4'hF) begin errors++; $display("[TB] FAIL read_launch got cyc/stb/we=%b adr=%h sel=%h want 110 30000004 f", {cyc, stb, we}, adr, sel); end
    // Fields changed after acceptance must not reach the bus.
    cmd_adr = 32'h3000_0018; cmd_we = 1'b1; cmd_sel = 4'h1;
    @(posedge clk); #1;
    checks++; if (adr !== 32'h3000_0004 || we !== 1'b0 || sel !== 4'hF || !cyc) begin errors++; $display("[TB] FAIL read_hold got adr=%h we=%b sel=%h cyc=%b want 30000004 0 f 1", adr, we, sel, cyc); end
    waitRsp(lat, seen);
    checks++; if (!seen || lat + 1 != 2) begin errors++; $display("[TB] FAIL read_latency got seen=%0d lat=%0d want seen=1 lat=2", seen, lat + 1); end
    checks++; if (rsp_dat !== 32'h4669626F || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL read_data got %h err=%b want 4669626f err=0", rsp_dat, rsp_err); end
    checks++; if (cyc !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL read_done got cyc=%b ready=%b want 0 0", cyc, cmd_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL read_pulse got rsp_valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_write_read;
    bit ok, seen;
    int lat;
    driveCmd(1'b1, 32'h3000_0018, 32'hCAFE_BABE, 4'hF, ok);
    checks++; if (!ok || we !== 1'b1 || datO !== 32'hCAFE_BABE) begin errors++; $display("[TB] FAIL write_launch got ok=%0d we=%b dat=%h want 1 1 cafebabe", ok, we, datO); end
    waitRsp(lat, seen);
    checks++; if (!seen || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL write_rsp got seen=%0d dat=%h err=%b want 1 0 0", seen, rsp_dat, rsp_err); end
    driveCmd(1'b0, 32'h3000_001C, 32'h0, 4'hF, ok);
    waitRsp(lat, seen);
    checks++; if (!ok || !seen || rsp_dat !== 32'hCAFE_BABE) begin errors++; $display("[TB] FAIL readback got ok=%0d seen=%0d dat=%h want 1 1 cafebabe", ok, seen, rsp_dat); end
    checks++; if (lastGap < 1) begin errors++; $display("[TB] FAIL idle_gap got %0d want >=1", lastGap); end
  endtask

  task automatic test_timeout;
    bit ok, seen;
    int lat, stbCycles;
    driveCmd(1'b0, 32'h2FFF_FFF0, 32'h0, 4'hF, ok);
    stbCycles = cyc ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin seen = 1'b1; break; end
      if (cyc && stb && adr == 32'h2FFF_FFF0) stbCycles++;
    end
    checks++; if (!ok || !seen || stbCycles != 16) begin errors++; $display("[TB] FAIL timeout_len got ok=%0d seen=%0d stb_cycles=%0d want 1 1 16", ok, seen, stbCycles); end
    checks++; if (rsp_err !== 1'b1 || rsp_dat !== 32'h0 || cyc !== 1'b0) begin errors++; $display("[TB] FAIL timeout_rsp got err=%b dat=%h cyc=%b want 1 0 0", rsp_err, rsp_dat, cyc); end
    // Offer the next command during DONE; it must go out one cycle later.
    cmd_we = 1'b0; cmd_adr = 32'h3000_0004; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || cyc !== 1'b0) begin errors++; $display("[TB] FAIL post_tmo_idle got ready=%b cyc=%b want 1 0", cmd_ready, cyc); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (cyc !== 1'b1 || adr !== 32'h3000_0004) begin errors++; $display("[TB] FAIL post_tmo_accept got cyc=%b adr=%h want 1 30000004", cyc, adr); end
    waitRsp(lat, seen);
    checks++; if (!seen || rsp_err !== 1'b0 || rsp_dat !== 32'h4669626F) begin errors++; $display("[TB] FAIL post_tmo_read got seen=%0d err=%b dat=%h want 1 0 4669626f", seen, rsp_err, rsp_dat); end
  endtask

  task automatic test_poll;
    logic [31:0] vals [3];
    logic        chgs [3];
    int nUpd = 0;
    int nErr = 0;
    bit busOk = 1'b1;
    pollData = 32'd5;
    @(negedge clk);
    poll_en = 1'b1;
    for (int i = 0; i < 100 && nUpd < 3; i++) begin
      @(posedge clk); #1;
      if (cyc && (adr !== POLL_ADDR || sel !== 4'hF || we !== 1'b0)) busOk = 1'b0;
      if (poll_err) nErr++;
      if (poll_upd) begin
        vals[nUpd] = poll_val;
        chgs[nUpd] = poll_chg;
        nUpd++;
        if (nUpd == 2) pollData = 32'd8;
      end
    end
    poll_en = 1'b0;
    checks++; if (nUpd != 3 || nErr != 0) begin errors++; $display("[TB] FAIL poll_count got upd=%0d err=%0d want 3 0", nUpd, nErr); end
    checks++; if (!busOk) begin errors++; $display("[TB] FAIL poll_bus got bad adr/sel/we want %h f 0", POLL_ADDR); end
    checks++; if ({chgs[0], chgs[1], chgs[2]} !== 3'b101) begin errors++; $display("[TB] FAIL poll_chg got %b want 101", {chgs[0], chgs[1], chgs[2]}); end
    checks++; if (vals[0] !== 32'd5 || vals[1] !== 32'd5 || vals[2] !== 32'd8 || poll_val !== 32'd8) begin errors++; $display("[TB] FAIL poll_vals got %0d %0d %0d final %0d want 5 5 8 8", vals[0], vals[1], vals[2], poll_val); end
    nUpd = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (poll_upd || cyc) nUpd++;
    end
    checks++; if (nUpd != 0) begin errors++; $display("[TB] FAIL poll_disable got %0d active cycles want 0", nUpd); end
  endtask

  // Edge numbers count from the first edge that sees poll_en high.
  // Wrap at edge 7 sets pending; the command offered for edge 8 wins,
  // the poll follows at edge 12, and the next wrap (edge 15) launches at 16.
  task automatic test_cmd_vs_poll;
    int updEdge [2];
    int nUpd = 0;
    @(negedge clk);
    cmd_we = 1'b0; cmd_adr = 32'h3000_0004; cmd_sel = 4'hF;
    poll_en = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (e == 7) cmd_valid = 1'b1;
      if (e == 8) begin
        cmd_valid = 1'b0;
        checks++; if (cyc !== 1'b1 || adr !== 32'h3000_0004) begin errors++; $display("[TB] FAIL cmd_first got cyc=%b adr=%h want 1 30000004", cyc, adr); end
      end
      if (e == 10) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h4669626F) begin errors++; $display("[TB] FAIL cmd_first_rsp got valid=%b dat=%h want 1 4669626f", rsp_valid, rsp_dat); end
      end
      if (e == 12) begin
        checks++; if (cyc !== 1'b1 || adr !== POLL_ADDR) begin errors++; $display("[TB] FAIL poll_after got cyc=%b adr=%h want 1 %h", cyc, adr, POLL_ADDR); end
      end
      if (poll_upd) begin
        if (nUpd < 2) updEdge[nUpd] = e;
        nUpd++;
      end
    end
    poll_en = 1'b0;
    checks++; if (nUpd != 2 || updEdge[0] != 14 || updEdge[1] != 18) begin errors++; $display("[TB] FAIL poll_no_loss got n=%0d edges %0d %0d want 2 14 18", nUpd, updEdge[0], updEdge[1]); end
  endtask

  task automatic test_reset_mid_bus;
    bit ok;
    int stray = 0;
    driveCmd(1'b0, 32'h2FFF_FFF0, 32'h0, 4'hF, ok);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cyc !== 1'b1 || poll_val !== 32'd8) begin errors++; $display("[TB] FAIL pre_reset got cyc=%b poll_val=%h want 1 8", cyc, poll_val); end
    rst = 1'b1;
    #1;
    checks++; if ({cyc, stb, rsp_valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_async got cyc/stb/rsp=%b want 000", {cyc, stb, rsp_valid}); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || cyc) stray++;
    end
    checks++; if (stray != 0 || cmd_ready !== 1'b1 || poll_val !== 32'h0) begin errors++; $display("[TB] FAIL post_reset got stray=%0d ready=%b poll_val=%h want 0 1 0", stray, cmd_ready, poll_val); end
  endtask

  initial begin
    $display("[TB] starting wb_cmd_master bench");
    test_reset();
    test_read();
    test_write_read();
    test_timeout();
    test_poll();
    test_cmd_vs_poll();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
